bnn_pu_array: RTL and testbench
===============================

// Module: bnn_pu_array
// PURPOSE
//  Multi-channel binarised-neuron processing unit: N_CH neurons share one input activation stream,
//  each with its own weight word. Per beat: XNOR, popcount, 2*pc-WORD_W, signed accumulation.
//  After cfg_words beats, acc >= threshold emits one activation bit per channel.
//  Sits between the activation/weight fetch path and the output-activation packer, with valid/ready on both sides.
// PARAMETERS
//  WORD_W  64  bits per data/weight beat (power of 2, >=8)
//  N_CH    4   parallel neurons (channels)
//  ACC_W   16  signed accumulator / threshold width; must hold +-WORD_W*255
//  CNT_W   8   width of cfg_words and the beat counter
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  cfg_words    in   CNT_W        beats per dot product; sampled on first beat of each vector
//  i_valid      in   1            input beat valid
//  i_ready      out  1            input beat accepted when i_valid & i_ready
//  i_data       in   WORD_W       binary activations (1=+1, 0=-1)
//  i_weight     in   N_CH*WORD_W  weights, channel c at [c*WORD_W +: WORD_W]
//  i_threshold  in   N_CH*ACC_W   signed thresholds, sampled with last beat of vector
//  o_valid      out  1            activation vector valid
//  o_ready      in   1            downstream accepts when o_valid & o_ready
//  o_act        out  N_CH         bit c = (acc_c >= thr_c)
// BEHAVIOUR
//  Single clock; reset is synchronous and active-high. Reset: o_valid=0, o_act=0, beat counter=0,
//   all accumulators=0, pipeline valids=0; i_ready=1 in the cycle after reset deasserts.
//  Global stall: en = ~o_valid | o_ready; i_ready = en. All stages advance only when en=1;
//   when en=0 every register holds (o_act, o_valid stable).
//  Stage 1 (beat accepted): per channel pc_c = popcount(~(i_data ^ w_c)); register pc_c, last flag,
//   first flag, thresholds (when last).
//  Stage 2: term_c = 2*pc_c - WORD_W (signed, ACC_W); acc_c = first ? term_c : acc_c + term_c.
//   On last: o_act_c = (acc_c + term_c >= thr_c) signed compare, o_valid <= 1; acc not reused.
//  Latency: last beat accepted cycle t -> o_valid high cycle t+2. Throughput 1 beat/cycle; 
//   back-to-back vectors with no bubble; cfg_words=1 gives one result per cycle.
//  Beat counter: loads cfg_words on first beat; last when count reaches target; wraps to 0.
//   cfg_words=0 treated as 1. cfg_words changes mid-vector are ignored.
//  o_valid drops the cycle after handshake unless a new result loads in the same cycle.
//  No saturation: caller guarantees WORD_W*cfg_words fits ACC_W-1 magnitude bits.
//  Reset mid-vector: partial sums and in-flight beats discarded; next beat is a first beat.
// CONFIGURATION
//  BNNA_PU_SUM_OUT_EN defined: extra port o_sum out N_CH*ACC_W, raw final signed sums,
//   valid with o_valid, reset 0, held during stall.
//  Undefined: port absent, sums not retained past the compare; o_act behaviour identical.
// STRUCTURE
//  Package bnn_pu_pkg: popcount function, acc_t (signed ACC_W) typedef, WORD_W/ACC_W defaults,
//   helper to_signed_term(pc) = 2*pc - WORD_W.
//  Sub-module xnor_popcount (WORD_W-bit XNOR + adder tree), instantiated N_CH times in a generate loop.
//  Top holds counter, stall logic, stage registers, accumulators, comparators.
// TESTING
//  1 cfg_words=1, data={61'h1FFF_FFFF_FFFF_FFFF,3'b101}, w0={61'h0,3'b111}, thr0=8 -> pc=2,
//    sum=-60, o_act[0]=0; same with thr0=-60 -> o_act[0]=1; o_valid 2 cycles after accept.
//  2 cfg_words=3, data=weight on ch1 (sum +192), thr1=192 -> o_act[1]=1; thr1=193 -> 0;
//    ch2 weight=~data (sum -192), thr2=-192 -> 1.
//  3 backpressure: o_ready=0 for 5 cycles with results pending -> i_ready=0, o_valid/o_act stable,
//    no beat lost; o_ready=1 -> streaming resumes at 1 beat/cycle.
//  4 reset after 2 of 4 beats -> o_valid=0; next 4-beat vector gives correct sum with no residue.
//  5 cfg_words=0 and cfg_words=1 back-to-back 8 vectors, o_ready=1 -> 8 results on consecutive cycles.
//  6 BNNA_PU_SUM_OUT_EN: test 2 vectors -> o_sum ch1=192, ch2=-192; rebuild without macro -> o_act unchanged.

Source files
------------

// File: rtl/bnn_pu_pkg.sv
// rtl/bnn_pu_pkg.sv - shared types, defaults and helpers for the binarised-neuron PU array
package bnn_pu_pkg;

  localparam int DEF_WORD_W = 64;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_PC_W   = $clog2(DEF_WORD_W) + 1;

  typedef logic signed [DEF_ACC_W-1:0] acc_t;

  // Count of set bits in one default-width word
  function automatic logic [DEF_PC_W-1:0] popcount(input logic [DEF_WORD_W-1:0] x);
    logic [DEF_PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEF_WORD_W; i++) n = n + DEF_PC_W'(x[i]);
    return n;
  endfunction

  // Map a popcount to its +-1 dot-product contribution: 2*pc - WORD_W
  function automatic acc_t to_signed_term(input logic [DEF_PC_W-1:0] pc);
    return acc_t'({pc, 1'b0}) - acc_t'(DEF_WORD_W);
  endfunction

endpackage

// File: rtl/bnn_pu_array_xnor_popcount.sv
// rtl/bnn_pu_array_xnor_popcount.sv - per-channel XNOR of activations and weights followed by a bit count
module xnor_popcount #(
  parameter int WORD_W = 64,
  parameter int PC_W   = $clog2(WORD_W) + 1
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] w,
  output logic [PC_W-1:0]   pc
);

  logic [WORD_W-1:0] x;
  assign x = ~(a ^ w);

  // Sum of matching positions; synthesis builds this into an adder tree
  always_comb begin
    pc = '0;
    for (int i = 0; i < WORD_W; i++) pc = pc + PC_W'(x[i]);
  end

endmodule

// File: rtl/bnn_pu_array.sv
// rtl/bnn_pu_array.sv - N_CH binarised neurons on one activation stream; optional BNNA_PU_SUM_OUT_EN adds o_sum
module bnn_pu_array
  import bnn_pu_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int N_CH   = 4,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cfg_words,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [WORD_W-1:0]      i_data,
  input  logic [N_CH*WORD_W-1:0] i_weight,
  input  logic [N_CH*ACC_W-1:0]  i_threshold,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [N_CH-1:0]        o_act
`ifdef BNNA_PU_SUM_OUT_EN
  ,
  output logic [N_CH*ACC_W-1:0]  o_sum
`endif
);

  localparam int PC_W = $clog2(WORD_W) + 1;

  logic                    en, accept, first, last;
  logic [CNT_W-1:0]        cnt, tgt_q, target, cnt_inc;
  logic [PC_W-1:0]         pc_w   [N_CH];
  logic                    s1_valid, s1_first, s1_last;
  logic [PC_W-1:0]         s1_pc  [N_CH];
  logic [N_CH*ACC_W-1:0]   s1_thr;
  logic signed [ACC_W-1:0] acc     [N_CH];
  logic signed [ACC_W-1:0] sum_nxt [N_CH];

  assign en      = ~o_valid | o_ready;
  assign i_ready = en;
  assign accept  = i_valid & en;
  assign first   = (cnt == '0);
  assign target  = first ? ((cfg_words == '0) ? CNT_W'(1) : cfg_words) : tgt_q;
  assign cnt_inc = cnt + CNT_W'(1);
  assign last    = (cnt_inc == target);

  genvar gc;
  generate
    for (gc = 0; gc < N_CH; gc++) begin : g_ch
      xnor_popcount #(.WORD_W(WORD_W), .PC_W(PC_W)) u_pc (
        .a  (i_data),
        .w  (i_weight[gc*WORD_W +: WORD_W]),
        .pc (pc_w[gc])
      );
    end
  endgenerate

  // Beat counter: latch the vector length on the first beat, wrap after the last
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      tgt_q <= '0;
    end else if (accept) begin
      if (first) tgt_q <= target;
      cnt <= last ? '0 : cnt_inc;
    end
  end

  // Stage 1: register popcounts, vector position flags and last-beat thresholds
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_thr   <= '0;
      for (int c = 0; c < N_CH; c++) s1_pc[c] <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= first;
        s1_last  <= last;
        if (last) s1_thr <= i_threshold;
        for (int c = 0; c < N_CH; c++) s1_pc[c] <= pc_w[c];
      end
    end
  end

  // Signed per-beat term added onto the running sum (a first beat starts from zero)
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sum_nxt[c] = (s1_first ? '0 : acc[c])
                 + ($signed(ACC_W'({s1_pc[c], 1'b0})) - $signed(ACC_W'(WORD_W)));
    end
  end

  // Stage 2: accumulate mid-vector, threshold and publish on the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_act   <= '0;
      for (int c = 0; c < N_CH; c++) acc[c] <= '0;
    end else if (en) begin
      o_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        for (int c = 0; c < N_CH; c++) begin
          if (s1_last) o_act[c] <= (sum_nxt[c] >= $signed(s1_thr[c*ACC_W +: ACC_W]));
          else         acc[c]   <= sum_nxt[c];
        end
      end
    end
  end

`ifdef BNNA_PU_SUM_OUT_EN
  // Raw final sums, loaded alongside o_act and held through stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      o_sum <= '0;
    end else if (en && s1_valid && s1_last) begin
      for (int c = 0; c < N_CH; c++) o_sum[c*ACC_W +: ACC_W] <= sum_nxt[c];
    end
  end
`endif

endmodule

// File: tb/tb_bnn_pu_array.sv
// tb/tb_bnn_pu_array.sv - directed self-checking bench for bnn_pu_array
module tb_bnn_pu_array;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   cfg_words;
  logic         i_valid;
  logic         i_ready;
  logic [63:0]  i_data;
  logic [255:0] i_weight;
  logic [63:0]  i_threshold;
  logic         o_valid;
  logic         o_ready;
  logic [3:0]   o_act;
`ifdef BNNA_PU_SUM_OUT_EN
  logic [63:0]  o_sum;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bnn_pu_array dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_words   (cfg_words),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .i_weight    (i_weight),
    .i_threshold (i_threshold),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_act       (o_act)
`ifdef BNNA_PU_SUM_OUT_EN
    ,
    .o_sum       (o_sum)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel c gets d when sel[c]=1, else ~d
  function automatic logic [255:0] wv(input logic [3:0] sel, input logic [63:0] d);
    logic [255:0] w;
    for (int c = 0; c < 4; c++) w[c*64 +: 64] = sel[c] ? d : ~d;
    return w;
  endfunction

  function automatic logic [63:0] tv(input logic [15:0] t3, input logic [15:0] t2,
                                     input logic [15:0] t1, input logic [15:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  task automatic beat(input logic [7:0] cw, input logic [63:0] d,
                      input logic [255:0] w, input logic [63:0] t);
    int n;
    cfg_words   = cw;
    i_data      = d;
    i_weight    = w;
    i_threshold = t;
    i_valid     = 1'b1;
    n = 0;
    while (!i_ready && n < 50) begin
      step();
      n++;
    end
    chk("beat_accept", {63'b0, i_ready}, 64'd1);
    step();
    i_valid = 1'b0;
  endtask

  localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D2 = 64'h0F0F_F0F0_AAAA_5555;
  localparam logic [63:0] D3 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] T1_DATA = {61'h1FFF_FFFF_FFFF_FFFF, 3'b101};

  initial begin
    reset = 1'b1; o_ready = 1'b1; i_valid = 1'b0;
    cfg_words = 8'd1; i_data = '0; i_weight = '0; i_threshold = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_o_valid", {63'b0, o_valid}, 64'd0);
    chk("rst_o_act", {60'b0, o_act}, 64'd0);
    chk("rst_i_ready", {63'b0, i_ready}, 64'd1);

    // single-beat vector: pc=2 on ch0 -> sum -60; other channels -62
    beat(8'd1, T1_DATA, 256'h7, tv(16'd0, 16'd0, 16'd0, 16'd8));
    chk("t1_lat_not_yet", {63'b0, o_valid}, 64'd0);
    step();
    chk("t1_valid", {63'b0, o_valid}, 64'd1);
    chk("t1_act_thr8", {60'b0, o_act}, 64'h0);
    step();
    chk("t1_valid_drop", {63'b0, o_valid}, 64'd0);
    beat(8'd1, T1_DATA, 256'h7, tv(16'd0, 16'd0, 16'd0, -16'sd60));
    step();
    chk("t1_act_thr_m60", {60'b0, o_act}, 64'h1);

    // three beats: ch0,ch1 match (+192), ch2,ch3 inverted (-192)
    beat(8'd3, D1, wv(4'b0011, D1), tv(-16'sd191, -16'sd192, 16'd192, 16'd0));
    beat(8'd3, D2, wv(4'b0011, D2), tv(-16'sd191, -16'sd192, 16'd192, 16'd0));
    beat(8'd3, D3, wv(4'b0011, D3), tv(-16'sd191, -16'sd192, 16'd192, 16'd0));
    step();
    chk("t2_valid", {63'b0, o_valid}, 64'd1);
    chk("t2_act_thr192", {60'b0, o_act}, 64'h7);
`ifdef BNNA_PU_SUM_OUT_EN
    chk("t6_sum_ch1", {48'b0, o_sum[31:16]}, 64'h00C0);
    chk("t6_sum_ch2", {48'b0, o_sum[47:32]}, 64'hFF40);
`endif
    beat(8'd3, D2, wv(4'b0011, D2), tv(-16'sd191, -16'sd192, 16'd193, 16'd0));
    beat(8'd3, D3, wv(4'b0011, D3), tv(-16'sd191, -16'sd192, 16'd193, 16'd0));
    beat(8'd3, D1, wv(4'b0011, D1), tv(-16'sd191, -16'sd192, 16'd193, 16'd0));
    step();
    chk("t2_act_thr193", {60'b0, o_act}, 64'h5);
    step();

    // backpressure with two results pending and a third beat waiting
    o_ready = 1'b0;
    beat(8'd1, D2, wv(4'b0011, D2), tv(16'd0, 16'd0, 16'd0, 16'd0));
    beat(8'd1, D2, wv(4'b1010, D2), tv(16'd0, 16'd0, 16'd0, 16'd0));
    cfg_words = 8'd1; i_data = D2; i_weight = wv(4'b1110, D2); i_threshold = '0;
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_i_ready", {63'b0, i_ready}, 64'd0);
      chk("t3_stall_o_valid", {63'b0, o_valid}, 64'd1);
      chk("t3_stall_o_act", {60'b0, o_act}, 64'h3);
      step();
    end
    o_ready = 1'b1;
    step();
    i_valid = 1'b0;
    chk("t3_resume_b_valid", {63'b0, o_valid}, 64'd1);
    chk("t3_resume_b_act", {60'b0, o_act}, 64'hA);
    step();
    chk("t3_resume_c_valid", {63'b0, o_valid}, 64'd1);
    chk("t3_resume_c_act", {60'b0, o_act}, 64'hE);
    step();
    chk("t3_drain", {63'b0, o_valid}, 64'd0);

    // reset after two of four beats; residue would pull ch0 to 128
    beat(8'd4, D1, wv(4'b0010, D1), tv(16'd257, 16'd257, -16'sd256, 16'd256));
    beat(8'd4, D1, wv(4'b0010, D1), tv(16'd257, 16'd257, -16'sd256, 16'd256));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_rst_o_valid", {63'b0, o_valid}, 64'd0);
    chk("t4_rst_i_ready", {63'b0, i_ready}, 64'd1);
    for (int k = 0; k < 4; k++)
      beat(8'd4, D3, wv(4'b1101, D3), tv(16'd257, 16'd257, -16'sd256, 16'd256));
    chk("t4_not_early", {63'b0, o_valid}, 64'd0);
    step();
    chk("t4_valid", {63'b0, o_valid}, 64'd1);
    chk("t4_act", {60'b0, o_act}, 64'h3);
    step();

    // eight one-beat vectors alternating cfg_words 0/1, results every cycle
    for (int k = 0; k < 8; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      beat(kk[0] ? 8'd1 : 8'd0, D2, wv(kk, D2), '0);
      if (k > 0) begin
        chk("t5_valid", {63'b0, o_valid}, 64'd1);
        chk("t5_act", {60'b0, o_act}, 64'(k - 1));
      end
    end
    step();
    chk("t5_last_valid", {63'b0, o_valid}, 64'd1);
    chk("t5_last_act", {60'b0, o_act}, 64'd7);
    step();
    chk("t5_drain", {63'b0, o_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
